// File: rtl/bisr_alloc_sequencer_if.sv
// Weight-buffer handshake and allocator bus seen by the BISR allocation sequencer.
// The master modport is the sequencer; slave is the buffer/allocator side.
interface bisr_alloc_sequencer_if #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
  logic                                  wbuf_valid;
  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] wbuf_data;
  logic                                  wbuf_ready;
  logic                                  recovery_done;
  logic                                  recovery_success;
  logic                                  wr_en;
  logic                                  allocation_start;
  logic                                  weight_valid;
  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] input_weights;
  logic [ADDR_WIDTH-1:0]                 read_addr;

  modport master (
    input  wbuf_valid, wbuf_data, recovery_done, recovery_success,
    output wbuf_ready, wr_en, allocation_start, weight_valid, input_weights, read_addr
  );

  modport slave (
    output wbuf_valid, wbuf_data, recovery_done, recovery_success,
    input  wbuf_ready, wr_en, allocation_start, weight_valid, input_weights, read_addr
  );
endinterface

// File: rtl/bisr_alloc_sequencer.sv
// Sequences fault-pattern load, weight-row feed, recovery check and read-address
// sweep for one BISR weight tile at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for envm_load_req or tile_start
// LOAD    | one-cycle fault-pattern write strobe to the allocator
// INIT    | one-cycle allocator init pulse, row counter cleared
// FEED    | streaming SYSTOLIC_SIZE rows from the weight buffer
// SETTLE  | dead cycle for the mapping table to absorb the last row
// CHECK   | waiting (bounded by TIMEOUT) for the recovery result
// COMPUTE | sweeping read_addr under compute_en
module bisr_alloc_sequencer #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int TIMEOUT       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic envm_load_req,
  input  logic tile_start,
  input  logic abort,
  input  logic compute_en,
  output logic busy,
  output logic compute_active,
  output logic tile_done,
  output logic tile_fail,
  bisr_alloc_sequencer_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [TMO_W-1:0]      TMO_LOAD = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, INIT, FEED, SETTLE, CHECK, COMPUTE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic [ADDR_WIDTH-1:0] read_addr_q;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  wr_en_q;
  logic                  alloc_start_q;
  logic                  wbuf_ready_q;
  logic                  busy_q;
  logic                  compute_active_q;
  logic                  tile_done_q;
  logic                  tile_fail_q;
  logic                  beat;

  assign beat = bus.wbuf_valid && wbuf_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      row_cnt          <= '0;
      read_addr_q      <= '0;
      tmo_cnt          <= '0;
      wr_en_q          <= 1'b0;
      alloc_start_q    <= 1'b0;
      wbuf_ready_q     <= 1'b0;
      busy_q           <= 1'b0;
      compute_active_q <= 1'b0;
      tile_done_q      <= 1'b0;
      tile_fail_q      <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      alloc_start_q <= 1'b0;
      tile_done_q   <= 1'b0;
      tile_fail_q   <= 1'b0;
      if (abort) begin
        state            <= IDLE;
        row_cnt          <= '0;
        read_addr_q      <= '0;
        tmo_cnt          <= '0;
        wbuf_ready_q     <= 1'b0;
        busy_q           <= 1'b0;
        compute_active_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // a simultaneous tile_start is dropped, not latched
            if (envm_load_req) begin
              state   <= LOAD;
              wr_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end else if (tile_start) begin
              state         <= INIT;
              alloc_start_q <= 1'b1;
              busy_q        <= 1'b1;
              row_cnt       <= '0;
            end
          end
          LOAD: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          INIT: begin
            state        <= FEED;
            wbuf_ready_q <= 1'b1;
            row_cnt      <= '0;
          end
          FEED: begin
            if (beat) begin
              if (row_cnt == LAST_ROW) begin
                state        <= SETTLE;
                wbuf_ready_q <= 1'b0;
                row_cnt      <= '0;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end
          end
          SETTLE: begin
            state   <= CHECK;
            tmo_cnt <= TMO_LOAD;
          end
          CHECK: begin
            if (bus.recovery_done) begin
              tmo_cnt <= '0;
              if (bus.recovery_success) begin
                state            <= COMPUTE;
                compute_active_q <= 1'b1;
                read_addr_q      <= '0;
              end else begin
                state       <= IDLE;
                tile_fail_q <= 1'b1;
                busy_q      <= 1'b0;
              end
            end else if (tmo_cnt == '0) begin
              state       <= IDLE;
              tile_fail_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt - 1'b1;
            end
          end
          COMPUTE: begin
            if (compute_en) begin
              if (read_addr_q == LAST_ROW) begin
                state            <= IDLE;
                read_addr_q      <= '0;
                tile_done_q      <= 1'b1;
                busy_q           <= 1'b0;
                compute_active_q <= 1'b0;
              end else begin
                read_addr_q <= read_addr_q + 1'b1;
              end
            end
          end
          default: begin
            state            <= IDLE;
            wbuf_ready_q     <= 1'b0;
            busy_q           <= 1'b0;
            compute_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // rows pass through untouched so a beat coinciding with abort still reaches the allocator
  assign bus.weight_valid     = (state == FEED) && bus.wbuf_valid;
  assign bus.input_weights    = (state == FEED) ? bus.wbuf_data : '0;
  assign bus.wbuf_ready       = wbuf_ready_q;
  assign bus.wr_en            = wr_en_q;
  assign bus.allocation_start = alloc_start_q;
  assign bus.read_addr        = read_addr_q;
  assign busy                 = busy_q;
  assign compute_active       = compute_active_q;
  assign tile_done            = tile_done_q;
  assign tile_fail            = tile_fail_q;

endmodule

// File: tb/tb_bisr_alloc_sequencer.sv
// Directed bench for bisr_alloc_sequencer: load, normal tile, stalled tile,
// recovery failure, timeout, load/start collision, abort and async reset.
module tb_bisr_alloc_sequencer;
  localparam int S  = 8;
  localparam int W  = 8;
  localparam int AW = $clog2(S);
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic envm_load_req = 1'b0;
  logic tile_start = 1'b0;
  logic abort = 1'b0;
  logic compute_en = 1'b0;
  logic busy, compute_active, tile_done, tile_fail;

  bisr_alloc_sequencer_if #(.SYSTOLIC_SIZE(S), .WEIGHT_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  bisr_alloc_sequencer #(.SYSTOLIC_SIZE(S), .WEIGHT_WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .envm_load_req(envm_load_req), .tile_start(tile_start),
    .abort(abort), .compute_en(compute_en), .busy(busy), .compute_active(compute_active),
    .tile_done(tile_done), .tile_fail(tile_fail), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // cumulative event counters sampled on the active edge (pre-edge values)
  int n_wr = 0, n_alloc = 0, n_beat = 0, n_done = 0, n_fail = 0, n_active = 0;
  logic [S*W-1:0] beat_log [0:63];

  always @(posedge clk) begin
    if (bus.wr_en) n_wr++;
    if (bus.allocation_start) n_alloc++;
    if (tile_done) n_done++;
    if (tile_fail) n_fail++;
    if (compute_active) n_active++;
    if (bus.weight_valid) begin
      if (n_beat < 64) beat_log[n_beat] = bus.input_weights;
      n_beat++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [S*W-1:0] row_of(input int v);
    logic [S*W-1:0] r;
    for (int b = 0; b < S; b++) r[b*W +: W] = W'(v);
    return r;
  endfunction

  // start a tile and stream 8 rows; optional 3-cycle stall after row 4
  task automatic run_feed(input bit stall, input bit pulse_done);
    tile_start = 1'b1;
    step();
    tile_start = 1'b0;
    check("init_alloc_start", 64'(bus.allocation_start), 64'd1);
    check("init_busy", 64'(busy), 64'd1);
    step();
    check("feed_ready", 64'(bus.wbuf_ready), 64'd1);
    for (int k = 0; k < S; k++) begin
      bus.wbuf_data  = row_of(k + 1);
      bus.wbuf_valid = 1'b1;
      step();
      if (stall && k == 3) begin
        bus.wbuf_valid = 1'b0;
        step();
        if (pulse_done) bus.recovery_done = 1'b1;
        step();
        bus.recovery_done = 1'b0;
        step();
        check("stall_still_feed", 64'(bus.wbuf_ready), 64'd1);
      end
    end
    bus.wbuf_valid = 1'b0;
    bus.wbuf_data  = '0;
    check("settle_ready_low", 64'(bus.wbuf_ready), 64'd0);
    check("settle_busy", 64'(busy), 64'd1);
  endtask

  task automatic finish_ok();
    bus.recovery_done    = 1'b1;
    bus.recovery_success = 1'b1;
    step();
    check("check_not_active", 64'(compute_active), 64'd0);
    step();
    bus.recovery_done    = 1'b0;
    bus.recovery_success = 1'b0;
    check("compute_active", 64'(compute_active), 64'd1);
    compute_en = 1'b1;
    for (int i = 0; i < S; i++) begin
      check("read_addr", 64'(bus.read_addr), 64'(i));
      check("no_done_early", 64'(tile_done), 64'd0);
      step();
    end
    compute_en = 1'b0;
    check("tile_done", 64'(tile_done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_addr", 64'(bus.read_addr), 64'd0);
    step();
    check("tile_done_1cyc", 64'(tile_done), 64'd0);
  endtask

  task automatic check_beats(input int start);
    check("beat_count", 64'(n_beat - start), 64'(S));
    for (int k = 0; k < S; k++)
      check("beat_data", 64'(beat_log[start + k]), 64'(row_of(k + 1)));
  endtask

  initial begin
    int b0, d0, f0, a0, al0, w0;
    bus.wbuf_valid = 1'b0;
    bus.wbuf_data = '0;
    bus.recovery_done = 1'b0;
    bus.recovery_success = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_ready", 64'(bus.wbuf_ready), 64'd0);
    check("rst_addr", 64'(bus.read_addr), 64'd0);
    check("rst_weights", 64'(bus.input_weights), 64'd0);
    check("rst_active", 64'(compute_active), 64'd0);
    rst_n = 1'b1;
    step();

    // fault-pattern load
    w0 = n_wr;
    envm_load_req = 1'b1;
    step();
    envm_load_req = 1'b0;
    check("load_wr_en", 64'(bus.wr_en), 64'd1);
    check("load_busy", 64'(busy), 64'd1);
    step();
    check("load_wr_en_off", 64'(bus.wr_en), 64'd0);
    check("load_busy_off", 64'(busy), 64'd0);
    step();
    check("load_wr_count", 64'(n_wr - w0), 64'd1);

    // normal tile
    b0 = n_beat; d0 = n_done; f0 = n_fail; al0 = n_alloc;
    run_feed(1'b0, 1'b0);
    finish_ok();
    check_beats(b0);
    check("t1_done_cnt", 64'(n_done - d0), 64'd1);
    check("t1_fail_cnt", 64'(n_fail - f0), 64'd0);
    check("t1_alloc_cnt", 64'(n_alloc - al0), 64'd1);

    // stalled tile with an early recovery_done pulse
    b0 = n_beat; d0 = n_done; f0 = n_fail;
    run_feed(1'b1, 1'b1);
    finish_ok();
    check_beats(b0);
    check("t2_done_cnt", 64'(n_done - d0), 64'd1);
    check("t2_fail_cnt", 64'(n_fail - f0), 64'd0);

    // recovery failure
    d0 = n_done; f0 = n_fail; a0 = n_active;
    run_feed(1'b0, 1'b0);
    bus.recovery_done = 1'b1;
    bus.recovery_success = 1'b0;
    step();
    step();
    bus.recovery_done = 1'b0;
    check("rf_tile_fail", 64'(tile_fail), 64'd1);
    check("rf_busy", 64'(busy), 64'd0);
    step();
    check("rf_fail_1cyc", 64'(tile_fail), 64'd0);
    check("rf_fail_cnt", 64'(n_fail - f0), 64'd1);
    check("rf_done_cnt", 64'(n_done - d0), 64'd0);
    check("rf_never_active", 64'(n_active - a0), 64'd0);

    // timeout: recovery_done held low
    f0 = n_fail;
    run_feed(1'b0, 1'b0);
    step();
    for (int i = 0; i < TO - 1; i++) step();
    check("to_not_yet", 64'(tile_fail), 64'd0);
    check("to_busy_yet", 64'(busy), 64'd1);
    step();
    check("to_tile_fail", 64'(tile_fail), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    step();
    check("to_fail_cnt", 64'(n_fail - f0), 64'd1);

    // load and start collide: load wins
    al0 = n_alloc; w0 = n_wr;
    envm_load_req = 1'b1;
    tile_start = 1'b1;
    step();
    envm_load_req = 1'b0;
    tile_start = 1'b0;
    check("col_wr_en", 64'(bus.wr_en), 64'd1);
    check("col_alloc", 64'(bus.allocation_start), 64'd0);
    step();
    step();
    step();
    check("col_busy", 64'(busy), 64'd0);
    check("col_alloc_cnt", 64'(n_alloc - al0), 64'd0);
    check("col_wr_cnt", 64'(n_wr - w0), 64'd1);

    // abort during FEED, coinciding with the 4th beat
    b0 = n_beat; d0 = n_done; f0 = n_fail;
    tile_start = 1'b1;
    step();
    tile_start = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      bus.wbuf_data = row_of(k + 1);
      bus.wbuf_valid = 1'b1;
      step();
    end
    bus.wbuf_data = row_of(4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    bus.wbuf_valid = 1'b1;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_ready", 64'(bus.wbuf_ready), 64'd0);
    check("ab_no_valid", 64'(bus.weight_valid), 64'd0);
    step();
    step();
    bus.wbuf_valid = 1'b0;
    check("ab_beats", 64'(n_beat - b0), 64'd4);
    check("ab_last_beat", 64'(beat_log[b0 + 3]), 64'(row_of(4)));
    check("ab_no_done", 64'(n_done - d0), 64'd0);
    check("ab_no_fail", 64'(n_fail - f0), 64'd0);

    // async reset mid-COMPUTE
    run_feed(1'b0, 1'b0);
    bus.recovery_done = 1'b1;
    bus.recovery_success = 1'b1;
    step();
    step();
    bus.recovery_done = 1'b0;
    bus.recovery_success = 1'b0;
    compute_en = 1'b1;
    step();
    step();
    step();
    check("pre_rst_addr", 64'(bus.read_addr), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", 64'(bus.read_addr), 64'd0);
    check("arst_active", 64'(compute_active), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(tile_done), 64'd0);
    compute_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
